fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequences instruction fetch ahead of the IF/ID pipeline register. Owns the PC and
//  runs a req/ack handshake to instruction memory. Drives IF/ID write-enable and flush,
//  plus the PC+4 and instruction data the register latches.
//  Absorbs decode-stage stalls, branch/jump redirects and variable-latency memory.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC value loaded on reset
//  TIMEOUT      16             cycles of unacknowledged req before fetch_err sets (>=2)
// PORTS
//  clk            in   1   single clock; all state updates on posedge
//  rst            in   1   synchronous, active-high reset
//  imem_req       out  1   fetch request; held until imem_ack
//  imem_addr      out  32  fetch address; stable while imem_req=1
//  imem_ack       in   1   memory accepted/completed request; may rise same cycle as req
//  imem_rdata     in   32  instruction; valid when imem_ack=1
//  stall          in   1   hazard unit: IF/ID must hold its contents
//  redirect_valid in   1   branch/jump taken: discard fetched path
//  redirect_pc    in   32  new PC; bits [1:0] ignored (forced 2'b00)
//  ifid_we        out  1   IF/ID register write strobe (one instruction per pulse)
//  ifid_flush     out  1   IF/ID register loads a bubble (inst=32'h0)
//  pc_plus_4      out  32  PC+4 of the delivered instruction, valid with ifid_we
//  inst           out  32  delivered instruction, valid with ifid_we
//  fetch_busy     out  1   request outstanding (state S_REQ/S_DRAIN with req high)
//  fetch_err      out  1   sticky: req unacked for TIMEOUT cycles; cleared only by rst
// BEHAVIOUR
//  - Reset (rst=1 at posedge): pc<=RESET_PC, state<=S_REQ, buffer cleared, fetch_err<=0,
//    timeout counter<=0. While rst=1, all outputs are 0 except ifid_flush=1.
//  - States: S_REQ, S_HOLD, S_DRAIN. The outputs imem_req/ifid_we/ifid_flush/inst/pc_plus_4
//    are combinational from state+inputs. All other outputs are registered.
//  - S_REQ: imem_req=1, imem_addr=pc.
//      ack & !stall & !redirect -> ifid_we=1, inst=imem_rdata, pc_plus_4=pc+4,
//                                  pc<=pc+4, stay S_REQ. Zero-wait memory gives 1 inst/cycle.
//      ack & stall & !redirect  -> buf<=imem_rdata, bufpc<=pc+4, pc<=pc+4, go S_HOLD
//      !ack & redirect          -> pc<=redirect_pc, ifid_flush=1, go S_DRAIN
//      ack & redirect           -> data discarded, pc<=redirect_pc, ifid_flush=1, stay S_REQ
//  - S_HOLD: imem_req=0.
//      !stall & !redirect -> ifid_we=1, inst=buf, pc_plus_4=bufpc, go S_REQ
//      redirect           -> buf dropped, pc<=redirect_pc, ifid_flush=1, go S_REQ
//  - S_DRAIN: imem_req=1, imem_addr=old (in-flight) address; request cannot be cancelled.
//      ack -> data discarded, go S_REQ (new pc issued next cycle)
//      further redirect -> pc<=new redirect_pc, ifid_flush=1, remain S_DRAIN
//  - Priority: redirect > stall. ifid_we and ifid_flush are never both 1.
//  - When stall=1, ifid_we=0 always. ifid_flush is allowed during stall, because redirect wins.
//  - PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 32'h0.
//  - Timeout: counter increments each cycle imem_req=1 & !imem_ack, and clears on ack.
//    At count==TIMEOUT-1 with no ack, fetch_err<=1 (sticky). The counter saturates.
//    The handshake continues unchanged.
//  - rst mid-transaction: any outstanding req is abandoned.
//    The memory must tolerate req dropping on reset.
// STRUCTURE
//  - fetch_pkg: typedef enum logic [1:0] {S_REQ, S_HOLD, S_DRAIN} fetch_state_t;
//    localparam NOP_INST = 32'h0.
//  - One sub-module: fetch_timeout_ctr (counter, saturate, sticky err), parameter TIMEOUT.
//  - The IF/ID register stays a separate instance. This block only drives its we/flush/data.
// TESTING
//  - Zero-wait: ack tied to req, rst released at RESET_PC=0
//    -> ifid_we every cycle, pc_plus_4 = 4,8,12,... and imem_addr = 0,4,8.
//  - 3-cycle memory latency -> imem_addr constant for 3 cycles, then one ifid_we pulse;
//    fetch_busy high throughout; fetch_err stays 0.
//  - Stall with ack at pc=0x10 -> S_HOLD, no ifid_we. Drop stall 2 cycles later
//    -> ifid_we with inst=buffered word, pc_plus_4=0x14, next imem_addr=0x14.
//  - Redirect to 0x103 while req at 0x20 unacked -> ifid_flush=1, imem_addr holds 0x20 until ack.
//    That data is not delivered. Next imem_addr=0x100.
//  - Redirect+stall same cycle in S_HOLD -> ifid_flush=1, ifid_we=0, buffer discarded.
//    Wrap case: redirect to 0xFFFF_FFFC, then ack -> pc_plus_4=0x0.
//  - Never ack, TIMEOUT=16 -> fetch_err rises after 16th unacked cycle and stays set.
//    A later ack does not clear it; rst does.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INST   = 32'h0;
    localparam logic [31:0] INST_BYTES = 32'd4;

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction memory req/ack bus between fetch and imem.
interface fetch_ctrl_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Counts unacknowledged request cycles; raises a sticky error at the limit.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic ack_i,
    output logic err_o
);

    localparam int unsigned W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (req_i && !ack_i) begin
            if (cnt_q == LAST) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (ack_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, runs the imem handshake, feeds IF/ID.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master imem,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         ifid_we,
    output logic         ifid_flush,
    output logic [31:0]  pc_plus_4,
    output logic [31:0]  inst,
    output logic         fetch_busy,
    output logic         fetch_err
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  buf_q, buf_d;
    logic [31:0]  bufpc_q, bufpc_d;
    logic         busy_q, busy_d;
    logic         req;
    logic         err;
    logic [31:0]  rpc;
    logic [31:0]  pc_inc;

    assign rpc    = align_pc(redirect_pc);
    assign pc_inc = pc_q + INST_BYTES;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_d      = buf_q;
        bufpc_d    = bufpc_q;
        req        = 1'b0;
        ifid_we    = 1'b0;
        ifid_flush = 1'b0;
        inst       = NOP_INST;
        pc_plus_4  = '0;
        case (state_q)
            S_REQ: begin
                req = 1'b1;
                if (redirect_valid) begin
                    ifid_flush = 1'b1;
                    pc_d       = rpc;
                    state_d    = imem.imem_ack ? S_REQ : S_DRAIN;
                end else if (imem.imem_ack) begin
                    pc_d = pc_inc;
                    if (stall) begin
                        buf_d   = imem.imem_rdata;
                        bufpc_d = pc_inc;
                        state_d = S_HOLD;
                    end else begin
                        ifid_we   = 1'b1;
                        inst      = imem.imem_rdata;
                        pc_plus_4 = pc_inc;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    ifid_flush = 1'b1;
                    pc_d       = rpc;
                    state_d    = S_REQ;
                end else if (!stall) begin
                    ifid_we   = 1'b1;
                    inst      = buf_q;
                    pc_plus_4 = bufpc_q;
                    state_d   = S_REQ;
                end
            end
            S_DRAIN: begin
                // The in-flight request cannot be cancelled; only retarget pc.
                req = 1'b1;
                if (redirect_valid) begin
                    ifid_flush = 1'b1;
                    pc_d       = rpc;
                end
                if (imem.imem_ack) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
        if (rst) begin
            req        = 1'b0;
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
            inst       = NOP_INST;
            pc_plus_4  = '0;
        end
    end

    assign addr_d = (state_d == S_DRAIN) ? addr_q : pc_d;
    assign busy_d = (state_d != S_HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            buf_q   <= NOP_INST;
            bufpc_q <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            bufpc_q <= bufpc_d;
            busy_q  <= busy_d;
        end
    end

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .req_i (req),
        .ack_i (imem.imem_ack),
        .err_o (err)
    );

    assign imem.imem_req  = req;
    assign imem.imem_addr = rst ? '0 : addr_q;
    assign fetch_busy     = busy_q & ~rst;
    assign fetch_err      = err & ~rst;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl with a random-latency imem model.
module tb_fetch_ctrl;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pcp4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifid_we;
    logic        ifid_flush;
    logic [31:0] pc_plus_4;
    logic [31:0] inst;
    logic        fetch_busy;
    logic        fetch_err;

    fetch_ctrl_if bus();

    fetch_ctrl #(
        .RESET_PC (32'h0),
        .TIMEOUT  (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (bus),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_we        (ifid_we),
        .ifid_flush     (ifid_flush),
        .pc_plus_4      (pc_plus_4),
        .inst           (inst),
        .fetch_busy     (fetch_busy),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    int stall_pct = 0;
    int redir_pct = 0;
    int lat_min   = 0;
    int lat_max   = 0;
    bit never_ack = 1'b0;

    exp_t        q[$];
    logic [31:0] exp_pc = 32'h0;
    int          epoch = 0;
    int          req_epoch = 0;
    bit          in_req = 1'b0;
    logic [31:0] req_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    endtask

    // Memory and upstream stimulus: random latency, stall and redirects.
    initial begin
        int wait_cnt;
        int lat;
        logic [31:0] rp;
        wait_cnt = 0;
        lat = 0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            stall          = ($urandom_range(99) < stall_pct);
            redirect_valid = ($urandom_range(99) < redir_pct);
            rp = $urandom_range(4095);
            if ($urandom_range(7) == 0) rp = rp | 32'hFFFF_FFFC;
            redirect_pc = rp;
            if (rst) begin
                wait_cnt = 0;
                bus.imem_ack = 1'b0;
            end else if (bus.imem_req && !never_ack && wait_cnt >= lat) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem_word(bus.imem_addr);
                wait_cnt = 0;
                lat = $urandom_range(lat_max, lat_min);
            end else begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = $urandom;
                if (bus.imem_req) wait_cnt++;
            end
        end
    end

    // Reference model: architectural fetch stream with redirect epochs.
    always begin
        @(negedge clk);
        if (rst) begin
            q.delete();
            exp_pc = 32'h0;
            epoch++;
            in_req = 1'b0;
        end else begin
            if (bus.imem_req) begin
                if (!in_req) begin
                    in_req    = 1'b1;
                    req_epoch = epoch;
                    req_addr  = bus.imem_addr;
                    chk("fetch_addr", bus.imem_addr, exp_pc);
                end else begin
                    chk("addr_stable", bus.imem_addr, req_addr);
                end
                if (bus.imem_ack) begin
                    in_req = 1'b0;
                    if (req_epoch == epoch && !redirect_valid) begin
                        q.push_back('{mem_word(exp_pc), exp_pc + 32'd4});
                        exp_pc = exp_pc + 32'd4;
                    end
                end
            end
            if (redirect_valid) begin
                q.delete();
                epoch++;
                exp_pc = redirect_pc & ~32'h3;
            end
        end
    end

    // Monitor: pops on every IF/ID write.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (!rst) begin
            chk("flush", {31'h0, ifid_flush}, {31'h0, redirect_valid});
            if (ifid_we) begin
                chk("we_in_stall", {31'h0, stall}, 32'h0);
                if (q.size() == 0) begin
                    chk("spurious_we", 32'h1, 32'h0);
                end else begin
                    e = q.pop_front();
                    chk("inst", inst, e.inst);
                    chk("pc_plus_4", pc_plus_4, e.pcp4);
                end
            end
            if (!stall && !redirect_valid) chk("pending", q.size(), 32'h0);
            else if (q.size() > 1) chk("qdepth", q.size(), 32'h1);
        end
    end

    task automatic wait_we(input int lim);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (ifid_we) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_we", {31'h0, ok}, 32'h1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
        chk("rst_we", {31'h0, ifid_we}, 32'h0);
        chk("rst_flush", {31'h0, ifid_flush}, 32'h1);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pcp4", pc_plus_4, 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_busy", {31'h0, fetch_busy}, 32'h0);
        chk("rst_err", {31'h0, fetch_err}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Zero-wait memory: one instruction per cycle.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("zw_addr", bus.imem_addr, 32'(4 * k));
            chk("zw_we", {31'h0, ifid_we}, 32'h1);
            chk("zw_pcp4", pc_plus_4, 32'(4 * k + 4));
        end

        stall_pct = 30;
        redir_pct = 6;
        lat_min   = 0;
        lat_max   = 3;
        repeat (2000) @(negedge clk);
        stall_pct = 0;
        redir_pct = 0;
        repeat (10) @(negedge clk);
        chk("rand_err", {31'h0, fetch_err}, 32'h0);

        // Fixed three-cycle latency.
        lat_min = 2;
        lat_max = 2;
        wait_we(20);
        wait_we(20);
        @(negedge clk);
        a0 = bus.imem_addr;
        chk("l3_busy1", {31'h0, fetch_busy}, 32'h1);
        chk("l3_we1", {31'h0, ifid_we}, 32'h0);
        @(negedge clk);
        chk("l3_addr2", bus.imem_addr, a0);
        chk("l3_busy2", {31'h0, fetch_busy}, 32'h1);
        chk("l3_we2", {31'h0, ifid_we}, 32'h0);
        @(negedge clk);
        chk("l3_addr3", bus.imem_addr, a0);
        chk("l3_busy3", {31'h0, fetch_busy}, 32'h1);
        chk("l3_we3", {31'h0, ifid_we}, 32'h1);
        chk("l3_err", {31'h0, fetch_err}, 32'h0);

        // Timeout: never acknowledge.
        lat_min   = 0;
        lat_max   = 0;
        never_ack = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("to_err_low", {31'h0, fetch_err}, 32'h0);
            chk("to_busy", {31'h0, fetch_busy}, 32'h1);
        end
        @(negedge clk);
        chk("to_err_set", {31'h0, fetch_err}, 32'h1);
        never_ack = 1'b0;
        repeat (5) @(negedge clk);
        chk("to_err_sticky", {31'h0, fetch_err}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("to_err_rst", {31'h0, fetch_err}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("to_err_cleared", {31'h0, fetch_err}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
